// File: rtl/ir_command_decoder.sv
// NEC frame validator and command mapper: checks the frame integrity, then drives ir_button, state_control and toggle.
// The repeat-suppression hold-off is built only when IR_REPEAT_SUPPRESS_EN is defined.
module ir_command_decoder #(
  parameter int          CLK_HZ      = 50_000_000,
  parameter int          HOLDOFF_MS  = 200,
  parameter logic [15:0] CUSTOM_CODE = 16'h6B86,
  parameter logic [7:0]  POWER_KEY   = 8'h12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir_data,
  input  logic        data_ready,
  output logic [7:0]  ir_button,
  output logic [2:0]  state_control,
  output logic        toggle,
  output logic        cmd_valid,
  output logic        frame_error,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, EMIT = 2'd2, HOLDOFF = 2'd3} state_t;

  state_t      state;
  logic        dr_q;
  logic        dr_q2;
  logic        dr_edge;
  logic [31:0] frame;
  logic        frame_valid;

  // A new frame is a rising edge of the registered data_ready level.
  assign dr_edge     = dr_q & ~dr_q2;
  assign frame_valid = (frame[31:24] == ~frame[23:16]) && (frame[15:0] == CUSTOM_CODE);
  assign dbg_state   = state;

`ifdef IR_REPEAT_SUPPRESS_EN
  localparam int HOLDOFF_CYCLES = CLK_HZ / 1000 * HOLDOFF_MS;
  localparam int CW             = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLDOFF_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          in_valid;

  // The HOLDOFF state judges the incoming frame directly, without a CHECK pass.
  assign in_valid = (ir_data[31:24] == ~ir_data[23:16]) && (ir_data[15:0] == CUSTOM_CODE);
`else
  logic unused_holdoff;
  assign unused_holdoff = (CLK_HZ != 0) && (HOLDOFF_MS != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dr_q          <= 1'b0;
      dr_q2         <= 1'b0;
      frame         <= 32'h0;
      ir_button     <= 8'h00;
      state_control <= 3'd0;
      toggle        <= 1'b0;
      cmd_valid     <= 1'b0;
      frame_error   <= 1'b0;
`ifdef IR_REPEAT_SUPPRESS_EN
      cnt           <= '0;
`endif
    end else begin
      dr_q        <= data_ready;
      dr_q2       <= dr_q;
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (dr_edge) begin
            frame <= ir_data;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (frame_valid) begin
            ir_button <= frame[23:16];
            cmd_valid <= 1'b1;
            if (frame[23:16] < 8'h08)
              state_control <= frame[18:16];
            else if (frame[23:16] == POWER_KEY)
              toggle <= ~toggle;
            state <= EMIT;
          end else begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end
        end
        EMIT: begin
`ifdef IR_REPEAT_SUPPRESS_EN
          cnt   <= CNT_LOAD;
          state <= HOLDOFF;
`else
          state <= IDLE;
`endif
        end
        HOLDOFF: begin
`ifdef IR_REPEAT_SUPPRESS_EN
          if (dr_edge && in_valid && (ir_data[23:16] != ir_button)) begin
            frame <= ir_data;
            state <= CHECK;
          end else begin
            // Same-key repeats fall through here silently; bad frames only flag an error.
            if (dr_edge && !in_valid)
              frame_error <= 1'b1;
            if (cnt == '0)
              state <= IDLE;
            else
              cnt <= cnt - 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ir_command_decoder.md
# ir_command_decoder

Consumes the 32-bit NEC frame and data-ready flag produced by the IR receiver and turns it into validated robot commands. Checks frame integrity (command/inverse and custom code) and latches the button code. Maps buttons to a 3-bit state_control and a power toggle, and suppresses auto-repeat within a hold-off window. Sits between the IR receiver and the UART/JSON command transmitter.

## Interface
- CLK_HZ, 50_000_000, clock frequency in Hz.
- HOLDOFF_MS, 200, repeat-suppression window in ms.
- CUSTOM_CODE, 16'h6B86, required value of ir_data[15:0].
- POWER_KEY, 8'h12, key code that flips toggle.
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  asynchronous active-low reset.
- ir_data  input  32  decoded frame: [31:24] inverted key, [23:16] key, [15:0] custom code.
- data_ready  input  1  level flag from receiver; high while ir_data holds a completed frame.
- ir_button  output  8  last accepted key code.
- state_control  output  3  current drive state.
- toggle  output  1  power toggle; flips on each accepted POWER_KEY.
- cmd_valid  output  1  one-cycle pulse per accepted frame.
- frame_error  output  1  one-cycle pulse per rejected frame.

## Operation
- data_ready is registered once; new frame = registered high while previous registered value low (rising edge). Level-high without edge is ignored.
- FSM states: IDLE, CHECK, EMIT, HOLDOFF.
- IDLE: on edge, capture ir_data into frame register, go CHECK.
- CHECK: valid iff frame[31:24] == ~frame[23:16] and frame[15:0] == CUSTOM_CODE.
  - Invalid: pulse frame_error next cycle, return IDLE; no output changes.
  - Valid: go EMIT.
- EMIT (one cycle): ir_button <= key; cmd_valid pulses.
  - key 8'h00–8'h07: state_control <= key[2:0].
  - key == POWER_KEY: toggle <= ~toggle; state_control unchanged.
  - Other keys: ir_button updated, state_control/toggle unchanged.
  - Then go HOLDOFF, load counter with HOLDOFF_CYCLES-1 = CLK_HZ/1000*HOLDOFF_MS - 1.
- HOLDOFF: counter decrements each cycle; at 0 go IDLE.
  - Edge with valid frame and same key as ir_button: ignored, counter not reloaded, no pulses.
  - Edge with a different key: captured, go CHECK immediately (hold-off abandoned).
  - Edge with an invalid frame: frame_error pulses, remain in HOLDOFF, counter continues.
- Counter width: $clog2(HOLDOFF_CYCLES); no wrap, saturates at 0.

## Timing
- Reset (async, rst_n low): state IDLE, ir_button 8'h00, state_control 3'd0, toggle 0, cmd_valid 0, frame_error 0, counter 0, data_ready register 0.
- Cycle 0: registered data_ready shows rising edge. Cycle 1: CHECK. Cycle 2: EMIT registers outputs; cmd_valid high during cycle 2 only; new ir_button/state_control visible from cycle 2 onward.
- frame_error high for exactly the cycle after CHECK.
- cmd_valid and frame_error never high simultaneously.
- data_ready edges during CHECK or EMIT are ignored (receiver frames are ≥ 60 ms apart).
- Reset mid-hold-off or mid-EMIT: all outputs return to reset values at once; first edge after release is processed normally.

## Configuration
- IR_REPEAT_SUPPRESS_EN defined: HOLDOFF state and counter as above.
- Undefined: EMIT returns straight to IDLE; every valid frame, including repeated same key, produces cmd_valid; counter not instantiated; HOLDOFF_MS unused.

## Test plan
- Reset, then frame 32'hFE01_6B86 (key 0x01) with data_ready rise -> cmd_valid one cycle at edge+2, ir_button 0x01, state_control 3'd1.
- Frame 32'hED12_6B86 (POWER_KEY) twice, 250 ms apart -> two cmd_valid pulses, toggle 0→1→0.
- Frame 32'h0001_6B86 (bad inverse) and 32'hFB04_1234 (wrong custom code) -> frame_error one cycle each, outputs unchanged.
- With IR_REPEAT_SUPPRESS_EN: key 0x03 then key 0x03 at +100 ms -> one cmd_valid; key 0x05 at +120 ms -> accepted, state_control 3'd5; key 0x03 at +400 ms -> accepted.
- Assert rst_n low during HOLDOFF -> outputs at reset values immediately; next key 0x02 frame accepted normally, state_control 3'd2.
